gate_truth_table_sequencer: RTL and testbench
=============================================

GATE_TRUTH_TABLE_SEQUENCER -- requirements
Module: gate_truth_table_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 50_000_000, clock cycles per truth-table step (1 s at 50 MHz); minimum 2.
REQ-002 CLOCK_50_I  input  1  the single 50 MHz clock; all state SHALL be updated on its rising edge.
REQ-003 RESET_I  input  1  reset, synchronous and active-high.
REQ-004 PUSH_BUTTON_N_I  input  4  active-low push buttons: [0] START/STEP, [1] PAUSE/RESUME, [3:2] unused.
REQ-005 SWITCH_I  input  18  [2:0] function select, latched at START; [17:3] unused.
REQ-006 LED_RED_O  output  18  [15:0] captured truth table (bit i = f(i)); [17:16] latched function select [1:0].
REQ-007 LED_GREEN_O  output  9  [3:0] current input vector; [4] current f(vector); [5] DONE; [6] RUN; [7] HOLD; [8] latched select [2].

Function
REQ-008 Each button SHALL pass through a 2-flop synchroniser, then a falling-edge detector that yields a one-cycle press pulse.
REQ-009 The state register SHALL update on the 3rd rising edge after a button input falls; holding a button SHALL produce exactly one pulse.
REQ-010 States SHALL be IDLE, RUN, HOLD and DONE, encoded as an enum.
REQ-011 IDLE or DONE + START: clear the table, index=0, prescaler=0, latch SWITCH_I[2:0], go to RUN.
REQ-012 RUN: the prescaler SHALL count 0..STEP_CYCLES-1; at terminal count, table[index] SHALL capture f(index) and the prescaler SHALL wrap to 0.
REQ-013 RUN step at index 15: after capture, go to DONE with index held at 15; otherwise index SHALL increment by 1.
REQ-014 RUN + PAUSE: go to HOLD with the prescaler frozen and its value retained.
REQ-015 HOLD + PAUSE: return to RUN, resuming from the retained prescaler value.
REQ-016 HOLD + START: perform one immediate step (capture, then increment), stay in HOLD, leave the prescaler unchanged; at index 15 go to DONE.
REQ-017 If PAUSE and START pulse in the same cycle, PAUSE SHALL win and START SHALL be dropped.
REQ-018 In RUN, START SHALL be ignored; in IDLE or DONE, PAUSE SHALL be ignored.
REQ-019 If a prescaler terminal count coincides with a PAUSE pulse, the capture SHALL occur and the state SHALL then become HOLD.
REQ-020 f(v) for v[3:0] SHALL be selected by the latched select:
  - 0 AND2(v1,v0); 1 OR2(v1,v0); 2 AND3(v2..v0); 3 OR3(v2..v0)
  - 4 NAND4; 5 NOR4
  - 6 (v1&v0)|(v3&v2); 7 (v1&v0)^(v3&v2)
REQ-021 SWITCH_I changes after START SHALL NOT affect the running sweep.
REQ-022 LED_GREEN_O[4] SHALL be combinational from the index and the latched select.
REQ-023 All other outputs SHALL come directly from registers.

Reset
REQ-024 While RESET_I=1 at a clock edge, the block SHALL enter IDLE and clear index, prescaler, table and latched select to 0, and set the synchroniser and edge flops to 1 (released).
REQ-025 Reset value of every output SHALL be LED_RED_O=0 and LED_GREEN_O=0, except bit [4], which SHALL show f(0) with select 0 (=0).
REQ-026 Reset asserted mid-sweep SHALL abort without any capture in that cycle.
REQ-027 No spurious press SHALL be generated on reset release while a button is held.

Structure
REQ-028 Package gate_seq_pkg SHALL hold the state enum, the gate function enum (3 bit) and the default STEP_CYCLES constant.
REQ-029 Sub-module boolean_function_unit SHALL be purely combinational: inputs 3-bit select and 4-bit vector, output 1-bit result.
REQ-030 The prescaler width SHALL be $clog2(STEP_CYCLES).

Verification (STEP_CYCLES=4)
REQ-031 Select 0, press START, run to DONE -> LED_RED_O[15:0]=16'h8888, DONE=1, index=15; 64 cycles from RUN entry to DONE.
REQ-032 Select 5, full sweep -> table=16'h0001; select 7 -> 16'h0888 ^ 16'h7000 = 16'h7888.
REQ-033 PAUSE after 2 steps, then 3 START presses in HOLD -> table[4:0] captured and index=5; PAUSE resumes from the same prescaler value.
REQ-034 PAUSE and START pressed in the same cycle during RUN -> HOLD, no extra step.
REQ-035 RESET_I pulsed at index 9 during RUN -> next cycle IDLE with all outputs 0; START then restarts the sweep from index 0.
REQ-036 Button held low for 20 cycles in IDLE -> exactly one START action; SWITCH_I[2:0] changed mid-run -> table unchanged versus the latched function.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
package gate_seq_pkg;

  // One truth-table step per second at 50 MHz.
  localparam int unsigned DefaultStepCycles = 50_000_000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  typedef enum logic [2:0] {
    FnAnd2    = 3'd0,
    FnOr2     = 3'd1,
    FnAnd3    = 3'd2,
    FnOr3     = 3'd3,
    FnNand4   = 3'd4,
    FnNor4    = 3'd5,
    FnPairOr  = 3'd6,
    FnPairXor = 3'd7
  } gate_fn_e;

endpackage

// File: rtl/gate_truth_table_sequencer_if.sv
// Board-facing buttons, switches and LEDs of the sequencer.
interface gate_truth_table_sequencer_if;
  logic [3:0]  PUSH_BUTTON_N_I;
  logic [17:0] SWITCH_I;
  logic [17:0] LED_RED_O;
  logic [8:0]  LED_GREEN_O;

  // Board / testbench side drives the inputs and watches the LEDs
  modport master (
    output PUSH_BUTTON_N_I,
    output SWITCH_I,
    input  LED_RED_O,
    input  LED_GREEN_O
  );

  // Sequencer side
  modport slave (
    input  PUSH_BUTTON_N_I,
    input  SWITCH_I,
    output LED_RED_O,
    output LED_GREEN_O
  );
endinterface

// File: rtl/boolean_function_unit.sv
// Combinational evaluation of the selected gate function on a 4-bit input vector.
module boolean_function_unit
  import gate_seq_pkg::*;
(
  input  gate_fn_e   sel,
  input  logic [3:0] vec,
  output logic       result
);

  // Pair products shared by the two compound functions
  logic lo_pair, hi_pair;
  assign lo_pair = vec[1] & vec[0];
  assign hi_pair = vec[3] & vec[2];

  // Decode the function select
  always_comb begin
    result = 1'b0;
    unique case (sel)
      FnAnd2:    result = lo_pair;
      FnOr2:     result = vec[1] | vec[0];
      FnAnd3:    result = &vec[2:0];
      FnOr3:     result = |vec[2:0];
      FnNand4:   result = ~&vec;
      FnNor4:    result = ~|vec;
      FnPairOr:  result = lo_pair | hi_pair;
      FnPairXor: result = lo_pair ^ hi_pair;
      default:   result = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Steps through all 16 input vectors of a selected gate function, capturing its truth table.
module gate_truth_table_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DefaultStepCycles
) (
  input logic                         CLOCK_50_I,
  input logic                         RESET_I,
  gate_truth_table_sequencer_if.slave io
);

  localparam int unsigned       PrescW    = $clog2(STEP_CYCLES);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(STEP_CYCLES - 1);

  logic [1:0]        sync1_q, sync2_q, edge_q, armed_q, flush_q, press;
  logic              start, pause, step, fn_val;
  seq_state_e        state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [15:0]       table_q, table_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        flags_q;  // {hold, run, done}
  logic              unused_inputs;

  assign unused_inputs = ^{io.PUSH_BUTTON_N_I[3:2], io.SWITCH_I[17:3]};

  // Button synchronisers and falling-edge detectors. A button is only armed once a
  // genuine released sample has passed the synchroniser, so a button held across
  // reset release cannot fire.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      sync1_q <= '1;
      sync2_q <= '1;
      edge_q  <= '1;
      flush_q <= '0;
      armed_q <= '0;
    end else begin
      sync1_q <= io.PUSH_BUTTON_N_I[1:0];
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      flush_q <= {flush_q[0], 1'b1};
      armed_q <= armed_q | ({2{flush_q[1]}} & sync2_q);
    end
  end

  assign press = armed_q & edge_q & ~sync2_q;
  assign pause = press[1];
  assign start = press[0] & ~press[1];  // PAUSE wins a same-cycle collision

  boolean_function_unit u_bfu (
    .sel    (gate_fn_e'(sel_q)),
    .vec    (index_q),
    .result (fn_val)
  );

  // Sequencer next-state: start/pause handling, prescaler and table capture
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    presc_d = presc_q;
    table_d = table_q;
    sel_d   = sel_q;
    step    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          table_d = '0;
          index_d = '0;
          presc_d = '0;
          sel_d   = io.SWITCH_I[2:0];
          state_d = StRun;
        end
      end
      StRun: begin
        if (presc_q == PrescLast) begin
          step    = 1'b1;
          presc_d = '0;
        end else if (!pause) begin
          presc_d = presc_q + 1'b1;
        end
        if (pause) state_d = StHold;
      end
      StHold: begin
        if (pause)      state_d = StRun;
        else if (start) step    = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (step) begin
      table_d[index_q] = fn_val;
      // A pause that coincides with the last capture still lands in HOLD
      if (index_q == 4'hF) state_d = pause ? StHold : StDone;
      else                 index_d = index_q + 4'd1;
    end
  end

  // Sequencer state and registered status flags
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q <= StIdle;
      index_q <= '0;
      presc_q <= '0;
      table_q <= '0;
      sel_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      presc_q <= presc_d;
      table_q <= table_d;
      sel_q   <= sel_d;
      flags_q <= {state_d == StHold, state_d == StRun, state_d == StDone};
    end
  end

  assign io.LED_RED_O   = {sel_q[1:0], table_q};
  assign io.LED_GREEN_O = {sel_q[2], flags_q, fn_val, index_q};

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed and randomized checks of the truth-table sequencer against a behavioural model.
module tb_gate_truth_table_sequencer;

  localparam int unsigned Step = 4;
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MHold = 2;
  localparam int MDone = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Edge counter used to schedule button presses
  always @(posedge clk) cyc <= cyc + 1;

  gate_truth_table_sequencer_if bus ();

  gate_truth_table_sequencer #(.STEP_CYCLES(Step)) dut (
    .CLOCK_50_I (clk),
    .RESET_I    (rst),
    .io         (bus)
  );

  // Gate functions straight from their boolean definitions
  function automatic logic ref_f(input int sel, input int v);
    int b0, b1, b2, b3;
    b0 = v % 2;
    b1 = (v / 2) % 2;
    b2 = (v / 4) % 2;
    b3 = (v / 8) % 2;
    case (sel)
      0: return (b1 + b0) == 2;
      1: return (b1 + b0) > 0;
      2: return (b2 + b1 + b0) == 3;
      3: return (b2 + b1 + b0) > 0;
      4: return (b3 + b2 + b1 + b0) != 4;
      5: return v == 0;
      6: return (v % 4 == 3) || (v / 4 == 3);
      7: return (v % 4 == 3) != (v / 4 == 3);
      default: return 1'b0;
    endcase
  endfunction

  // Table with the first n entries captured
  function automatic logic [15:0] ref_table(input int sel, input int n);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = ref_f(sel, i);
    return t;
  endfunction

  function automatic logic [17:0] ref_red(input int sel, input int n);
    return {2'(sel % 4), ref_table(sel, n)};
  endfunction

  function automatic logic [8:0] ref_green(input int sel, input int idx, input int st);
    logic [8:0] g;
    g[3:0] = 4'(idx);
    g[4]   = ref_f(sel, idx);
    g[5]   = (st == MDone);
    g[6]   = (st == MRun);
    g[7]   = (st == MHold);
    g[8]   = (sel >= 4);
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int e);
    while (cyc < e) tick(1);
  endtask

  // Press and release; the action lands on the 3rd edge after the drop
  task automatic press(input int b);
    bus.PUSH_BUTTON_N_I[b] = 1'b0;
    tick(3);
    bus.PUSH_BUTTON_N_I[b] = 1'b1;
    tick(3);
  endtask

  task automatic wait_done(input int bound);
    int waited;
    waited = 0;
    while (bus.LED_GREEN_O[5] !== 1'b1 && waited < bound) begin
      tick(1);
      waited++;
    end
  endtask

  task automatic set_sel(input int sel);
    bus.SWITCH_I = {15'($urandom), 3'(sel)};
  endtask

  int sel, r, d, j, ticks, rem, q;

  initial begin
    rst = 1'b1;
    bus.PUSH_BUTTON_N_I = 4'hF;
    bus.SWITCH_I = '0;
    tick(3);
    check("reset_red", bus.LED_RED_O, 18'h0);
    check("reset_green", bus.LED_GREEN_O, ref_green(0, 0, MIdle));

    // START held across reset release must not fire
    bus.PUSH_BUTTON_N_I[0] = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(10);
    check("held_through_reset", bus.LED_GREEN_O, ref_green(0, 0, MIdle));
    bus.PUSH_BUTTON_N_I[0] = 1'b1;
    tick(5);

    // AND2 sweep, START held for 20 cycles
    sel = 0;
    set_sel(sel);
    d = cyc;
    bus.PUSH_BUTTON_N_I[0] = 1'b0;
    tick(3);
    r = d + 3;
    check("start_latency", bus.LED_GREEN_O, ref_green(sel, 0, MRun));
    tick(17);
    bus.PUSH_BUTTON_N_I[0] = 1'b1;
    wait_done(200);
    check("and2_sweep_len", cyc - r, 16 * Step);
    check("and2_red", bus.LED_RED_O, ref_red(sel, 16));
    check("and2_green", bus.LED_GREEN_O, ref_green(sel, 15, MDone));

    // Further sweeps with SWITCH_I scrambled after START
    for (int k = 0; k < 4; k++) begin
      sel = (k == 0) ? 5 : (k == 1) ? 7 : int'($urandom_range(0, 7));
      set_sel(sel);
      d = cyc;
      press(0);
      r = d + 3;
      bus.SWITCH_I = 18'($urandom);
      wait_done(200);
      check("sweep_len", cyc - r, 16 * Step);
      check("sweep_red", bus.LED_RED_O, ref_red(sel, 16));
      check("sweep_green", bus.LED_GREEN_O, ref_green(sel, 15, MDone));
    end

    // PAUSE after two steps, three single steps in HOLD, resume
    sel = int'($urandom_range(0, 7));
    set_sel(sel);
    d = cyc;
    press(0);
    r = d + 3;
    j = int'($urandom_range(8, 11));
    goto(r + j - 3);
    bus.PUSH_BUTTON_N_I[1] = 1'b0;
    tick(3);
    check("pause_green", bus.LED_GREEN_O, ref_green(sel, j / 4, MHold));
    check("pause_red", bus.LED_RED_O, ref_red(sel, j / 4));
    bus.PUSH_BUTTON_N_I[1] = 1'b1;
    tick(3);
    // Counting edges in RUN; the pause edge only counts if it completed a step
    ticks = (j % int'(Step) == 0) ? j : j - 1;
    rem = int'(Step) - ticks % int'(Step);
    press(0);
    press(0);
    bus.PUSH_BUTTON_N_I[0] = 1'b0;
    tick(20);
    bus.PUSH_BUTTON_N_I[0] = 1'b1;
    tick(3);
    check("hold_steps_green", bus.LED_GREEN_O, ref_green(sel, 5, MHold));
    check("hold_steps_red", bus.LED_RED_O, ref_red(sel, 5));
    d = cyc;
    bus.PUSH_BUTTON_N_I[1] = 1'b0;
    tick(3);
    q = d + 3;
    bus.PUSH_BUTTON_N_I[1] = 1'b1;
    goto(q + rem - 1);
    check("resume_before_step", bus.LED_GREEN_O, ref_green(sel, 5, MRun));
    tick(1);
    check("resume_step", bus.LED_GREEN_O, ref_green(sel, 6, MRun));
    wait_done(200);
    check("pause_sweep_red", bus.LED_RED_O, ref_red(sel, 16));
    check("pause_sweep_green", bus.LED_GREEN_O, ref_green(sel, 15, MDone));

    // PAUSE and START together in RUN, then together in HOLD
    sel = int'($urandom_range(0, 7));
    set_sel(sel);
    d = cyc;
    press(0);
    r = d + 3;
    j = int'($urandom_range(5, 7));
    goto(r + j - 3);
    bus.PUSH_BUTTON_N_I[1:0] = 2'b00;
    tick(3);
    check("both_run_green", bus.LED_GREEN_O, ref_green(sel, 1, MHold));
    check("both_run_red", bus.LED_RED_O, ref_red(sel, 1));
    bus.PUSH_BUTTON_N_I[1:0] = 2'b11;
    tick(3);
    bus.PUSH_BUTTON_N_I[1:0] = 2'b00;
    tick(3);
    check("both_hold_green", bus.LED_GREEN_O, ref_green(sel, 1, MRun));
    bus.PUSH_BUTTON_N_I[1:0] = 2'b11;

    // Reset pulse mid-run
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("reset_mid_red", bus.LED_RED_O, 18'h0);
    check("reset_mid_green", bus.LED_GREEN_O, ref_green(0, 0, MIdle));
    tick(5);

    // Reset lands on the edge that would capture index 9
    sel = int'($urandom_range(0, 7));
    set_sel(sel);
    d = cyc;
    press(0);
    r = d + 3;
    goto(r + 9 * int'(Step) + 3);
    check("idx9_green", bus.LED_GREEN_O, ref_green(sel, 9, MRun));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_red", bus.LED_RED_O, 18'h0);
    check("abort_green", bus.LED_GREEN_O, ref_green(0, 0, MIdle));
    tick(5);

    // Restart from index 0
    sel = int'($urandom_range(0, 7));
    set_sel(sel);
    d = cyc;
    press(0);
    r = d + 3;
    check("restart_green", bus.LED_GREEN_O, ref_green(sel, 0, MRun));
    check("restart_red", bus.LED_RED_O, ref_red(sel, 0));
    goto(r + int'(Step));
    check("restart_step_green", bus.LED_GREEN_O, ref_green(sel, 1, MRun));
    check("restart_step_red", bus.LED_RED_O, ref_red(sel, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
